// File: rtl/eth_rx_fcs_strip_pkg.sv
// Shared constants, types and CRC-32 helpers for the receive FCS checker/stripper.
package eth_rx_fcs_strip_pkg;

   localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
   localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;
   localparam int          ETH_MIN_FRAME = 64;
   localparam int          ETH_MAX_FRAME = 1518;
   localparam int          FCS_BYTES     = 4;

   typedef struct packed {
      logic       valid;
      logic       first;
      logic       last;
      logic [7:0] data;
   } outBeat_t;

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   localparam logic [31:0] CRC32_POLY_REFL = bitrev32(CRC32_POLY);

   // The register is kept in reflected (LSB-first) order, matching Ethernet bit order.
   function automatic logic [31:0] crc32Byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data[i]) begin
            c = (c >> 1) ^ CRC32_POLY_REFL;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_rx_fcs_strip_crc.sv
// Byte-wise reflected CRC-32 engine; o_match flags the good-frame residue.
module eth_rx_fcs_strip_crc
   import eth_rx_fcs_strip_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_gate,
   input  logic       i_first,
   input  logic [7:0] i_data,
   output logic       o_match
);

   logic [31:0] r_crc;
   logic [31:0] w_seed;

   // A frame-start byte always seeds from init, so a stale register can never leak in.
   assign w_seed = i_first ? CRC32_INIT : r_crc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_crc <= CRC32_INIT;
      end else if (i_gate) begin
         r_crc <= crc32Byte(w_seed, i_data);
      end
   end

   assign o_match = (bitrev32(r_crc) == CRC32_RESIDUE);

endmodule

// File: rtl/eth_rx_fcs_strip.sv
// Receive-side Ethernet FCS checker: strips the 4 trailing FCS bytes through a
// 4-byte delay line and posts a per-frame status strobe.
module eth_rx_fcs_strip
   import eth_rx_fcs_strip_pkg::*;
#(
   parameter int MIN_LEN = ETH_MIN_FRAME,
   parameter int MAX_LEN = ETH_MAX_FRAME,
   parameter int LEN_W   = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic [7:0]       out_data,
   output logic             out_valid,
   output logic             out_first,
   output logic             out_last,
   output logic             stat_valid,
   output logic             stat_crc_ok,
   output logic             stat_runt,
   output logic             stat_giant,
   output logic [LEN_W-1:0] stat_len
);

   localparam logic [LEN_W-1:0] LEN_SAT = '1;

   logic             r_frameStart;
   logic [2:0]       r_fill;
   logic [LEN_W-1:0] r_byteCount;
   logic [3:0][7:0]  r_delay;
   logic             r_emitted;
   outBeat_t         r_outBeat;
   logic             r_statValid;
   logic             r_statRunt;
   logic             r_statGiant;
   logic [LEN_W-1:0] r_statLen;

   logic [LEN_W-1:0] w_lenNext;
   logic             w_emit;
   logic             w_crcMatch;
   logic             w_endFrame;

   assign w_lenNext  = r_frameStart ? LEN_W'(1)
                     : ((r_byteCount == LEN_SAT) ? LEN_SAT : r_byteCount + LEN_W'(1));
   assign w_emit     = in_valid && (r_fill == 3'd4);
   assign w_endFrame = in_valid && in_last;

   eth_rx_fcs_strip_crc u_crc (
      .clk     (clk),
      .rst     (rst),
      .i_gate  (in_valid),
      .i_first (r_frameStart),
      .i_data  (in_data),
      .o_match (w_crcMatch)
   );

   // Delay line, fill level and byte count; the final byte empties the line so the
   // buffered FCS bytes are dropped and cannot reach the next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frameStart <= 1'b1;
         r_fill       <= 3'd0;
         r_byteCount  <= '0;
         r_delay      <= '0;
         r_emitted    <= 1'b0;
      end else if (in_valid) begin
         r_delay      <= {r_delay[2:0], in_data};
         r_byteCount  <= w_lenNext;
         r_frameStart <= in_last;
         if (in_last) begin
            r_fill    <= 3'd0;
            r_emitted <= 1'b0;
         end else begin
            r_fill <= (r_fill == 3'd4) ? 3'd4 : r_fill + 3'd1;
            if (w_emit) begin
               r_emitted <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_outBeat   <= '0;
         r_statValid <= 1'b0;
         r_statRunt  <= 1'b0;
         r_statGiant <= 1'b0;
         r_statLen   <= '0;
      end else begin
         r_outBeat.valid <= w_emit;
         r_outBeat.first <= w_emit && !r_emitted;
         r_outBeat.last  <= w_emit && in_last;
         r_outBeat.data  <= r_delay[3];
         r_statValid     <= w_endFrame;
         if (w_endFrame) begin
            r_statLen   <= w_lenNext;
            r_statRunt  <= (w_lenNext < LEN_W'(MIN_LEN));
            r_statGiant <= (w_lenNext > LEN_W'(MAX_LEN));
         end
      end
   end

   assign out_data    = r_outBeat.data;
   assign out_valid   = r_outBeat.valid;
   assign out_first   = r_outBeat.first;
   assign out_last    = r_outBeat.last;
   assign stat_valid  = r_statValid;
   assign stat_runt   = r_statValid & r_statRunt;
   assign stat_giant  = r_statValid & r_statGiant;
   assign stat_len    = r_statValid ? r_statLen : '0;
   // Frames of FCS length or less carry no payload and are never reported as good.
   assign stat_crc_ok = r_statValid & w_crcMatch & (r_statLen > LEN_W'(FCS_BYTES));

endmodule

// File: tb/tb_eth_rx_fcs_strip.sv
// Scoreboard bench for eth_rx_fcs_strip: driver queues expected beats/status,
// a negedge monitor pops and compares them.
module tb_eth_rx_fcs_strip;

   logic        clk;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_first;
   logic        out_last;
   logic        stat_valid;
   logic        stat_crc_ok;
   logic        stat_runt;
   logic        stat_giant;
   logic [10:0] stat_len;

   typedef struct {
      logic [7:0] data;
      logic       first;
      logic       last;
   } beat_t;

   typedef struct {
      logic        crcOk;
      logic        runt;
      logic        giant;
      logic [10:0] len;
      logic        lastTogether;
   } stat_t;

   beat_t      expBeatQ[$];
   stat_t      expStatQ[$];
   logic [7:0] frameBuf[$];
   int         compared   = 0;
   int         mismatched = 0;
   logic       prevAcc    = 1'b0;
   logic       prevLast   = 1'b0;

   eth_rx_fcs_strip dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_first   (out_first),
      .out_last    (out_last),
      .stat_valid  (stat_valid),
      .stat_crc_ok (stat_crc_ok),
      .stat_runt   (stat_runt),
      .stat_giant  (stat_giant),
      .stat_len    (stat_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      prevAcc  <= in_valid && !rst;
      prevLast <= in_valid && in_last && !rst;
   end

   // Monitor: outputs only move on posedge, so every negedge is a stable sample point.
   always @(negedge clk) begin
      beat_t eb;
      stat_t es;
      if (!prevAcc) begin
         compared++;
         if (out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL gapValid: out_valid=%b with no byte accepted, want 0", out_valid);
         end
      end else if (out_valid === 1'b1) begin
         compared++;
         if (expBeatQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL extraBeat: got data=%02h with nothing expected", out_data);
         end else begin
            eb = expBeatQ.pop_front();
            if (out_data !== eb.data || out_first !== eb.first || out_last !== eb.last) begin
               mismatched++;
               $display("[TB] FAIL payload: got data=%02h first=%b last=%b, want data=%02h first=%b last=%b",
                        out_data, out_first, out_last, eb.data, eb.first, eb.last);
            end
         end
      end
      compared++;
      if (stat_valid !== prevLast) begin
         mismatched++;
         $display("[TB] FAIL statTiming: stat_valid=%b, want %b", stat_valid, prevLast);
      end
      if (stat_valid === 1'b1) begin
         compared++;
         if (expStatQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL extraStat: got stat_len=%0d with nothing expected", stat_len);
         end else begin
            es = expStatQ.pop_front();
            if (stat_crc_ok !== es.crcOk || stat_runt !== es.runt || stat_giant !== es.giant ||
                stat_len !== es.len || out_last !== es.lastTogether) begin
               mismatched++;
               $display("[TB] FAIL status: got crc_ok=%b runt=%b giant=%b len=%0d out_last=%b, want crc_ok=%b runt=%b giant=%b len=%0d out_last=%b",
                        stat_crc_ok, stat_runt, stat_giant, stat_len, out_last,
                        es.crcOk, es.runt, es.giant, es.len, es.lastTogether);
            end
         end
      end
   end

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   // Stimulus helper: MSB-first CRC over LSB-first bits, then reflected and inverted.
   task automatic appendFcs();
      logic [31:0] c;
      logic [31:0] f;
      logic        fb;
      int          n;
      n = frameBuf.size();
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 8; b++) begin
            fb = c[31] ^ frameBuf[i][b];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C1_1DB7;
         end
      end
      f = ~bitrev32(c);
      for (int k = 0; k < 4; k++) frameBuf.push_back(f[8*k +: 8]);
   endtask

   task automatic loadTest1(input bit corrupt);
      frameBuf.delete();
      for (int i = 0; i < 9; i++) frameBuf.push_back(8'h31 + 8'(i));
      frameBuf.push_back(8'h26);
      frameBuf.push_back(8'h39);
      frameBuf.push_back(8'hF4);
      frameBuf.push_back(corrupt ? 8'hCA : 8'hCB);
   endtask

   task automatic loadPattern(input int payLen, input bit zeros, input bit withFcs);
      frameBuf.delete();
      for (int i = 0; i < payLen; i++) frameBuf.push_back(zeros ? 8'h00 : 8'(i * 7 + 3));
      if (withFcs) appendFcs();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives frameBuf; abortAfter>0 sends only that many bytes and never raises in_last.
   task automatic applyStimulus(input bit randomGaps, input bit expCrcOk, input int abortAfter);
      int    n;
      int    sendCount;
      int    g;
      stat_t st;
      n         = frameBuf.size();
      sendCount = (abortAfter > 0) ? abortAfter : n;
      for (int i = 0; i < sendCount; i++) begin
         if (randomGaps && i > 0) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
               in_valid = 1'b0;
               in_last  = 1'b0;
               @(posedge clk);
               #1;
            end
         end
         in_valid = 1'b1;
         in_data  = frameBuf[i];
         in_last  = (abortAfter == 0) && (i == n - 1);
         if (i >= 4) expBeatQ.push_back('{data: frameBuf[i-4], first: (i == 4), last: in_last});
         if (in_last) begin
            st.crcOk        = expCrcOk;
            st.runt         = (n < 64);
            st.giant        = (n > 1518);
            st.len          = (n > 2047) ? 11'd2047 : 11'(n);
            st.lastTogether = (n > 4);
            expStatQ.push_back(st);
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic checkOutput(input string name);
      compared++;
      if ({out_valid, out_first, out_last, out_data, stat_valid, stat_crc_ok,
           stat_runt, stat_giant, stat_len} !== 26'd0) begin
         mismatched++;
         $display("[TB] FAIL %s: outputs v=%b f=%b l=%b d=%02h sv=%b ok=%b r=%b g=%b len=%0d, want all 0",
                  name, out_valid, out_first, out_last, out_data, stat_valid, stat_crc_ok,
                  stat_runt, stat_giant, stat_len);
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("resetState");
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      $display("[TB] scenario 1: 123456789 + good FCS");
      loadTest1(1'b0);
      applyStimulus(1'b0, 1'b1, 0);
      idle(3);

      $display("[TB] scenario 2: corrupted FCS");
      loadTest1(1'b1);
      applyStimulus(1'b0, 1'b0, 0);
      idle(3);

      $display("[TB] scenario 3: 60 zero bytes with gaps");
      loadPattern(60, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 0);
      idle(3);

      $display("[TB] scenario 4: back-to-back frames");
      loadTest1(1'b0);
      applyStimulus(1'b0, 1'b1, 0);
      loadPattern(60, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 0);
      idle(3);

      $display("[TB] scenario 5: 3-byte runt, 4-byte FCS-only, 5-byte frame");
      frameBuf.delete();
      frameBuf.push_back(8'hAA);
      frameBuf.push_back(8'hBB);
      frameBuf.push_back(8'hCC);
      applyStimulus(1'b0, 1'b0, 0);
      loadPattern(0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 0);
      loadPattern(1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 0);
      idle(3);

      $display("[TB] scenario 6: reset mid-frame then good frame");
      loadPattern(40, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 20);
      idle(1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midFrameReset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      loadTest1(1'b0);
      applyStimulus(1'b0, 1'b1, 0);
      idle(3);

      $display("[TB] boundaries: 1519-byte giant and saturating 2100-byte frame");
      loadPattern(1515, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 0);
      loadPattern(2096, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 0);
      idle(5);

      compared++;
      if (expBeatQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL leftoverBeats: %0d beats never emitted, want 0", expBeatQ.size());
      end
      compared++;
      if (expStatQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL leftoverStats: %0d strobes never seen, want 0", expStatQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
